// File: rtl/csc_pkg.sv
// Shared CSC definitions: element/index widths, the token layout and the decoder FSM states.
// The encoder packs tokens with this same layout, so field order here is part of the stream format.
package csc_pkg;
  localparam int DATA_W = 8;
  localparam int DIM_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DIM_W-1:0]  row;
    logic              last;
    logic              empty;
  } csc_token_t;

  localparam int TOKEN_W = $bits(csc_token_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } csc_state_t;
endpackage

// File: rtl/csc_token_skid.sv
// One-entry pending-token register P. A token can be retired and the next one captured
// in the same cycle, which is what lets the decoder keep one dense element per cycle.
module csc_token_skid
  import csc_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               accept_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOKEN_W-1:0] in_token,
  input  logic               consume,
  output logic               p_valid,
  output logic [TOKEN_W-1:0] p_token
);
  assign in_ready = accept_en && (!p_valid || consume);

  always_ff @(posedge clock) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_token <= '0;
    end else if (flush) begin
      p_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      p_valid <= 1'b1;
      p_token <= in_token;
    end else if (consume) begin
      p_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/csc_matrix_decoder.sv
// CSC-to-dense decoder: walks (r, c) over an HxW matrix in column-major order, emitting the
// pending token's value where its row matches and zero everywhere else.
module csc_matrix_decoder #(
  parameter int DATA_W = csc_pkg::DATA_W,
  parameter int DIM_W  = csc_pkg::DIM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  matrix_height,
  input  logic [DIM_W-1:0]  matrix_width,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DIM_W-1:0]  in_row,
  input  logic              in_last,
  input  logic              in_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              out_col_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import csc_pkg::*;

  csc_state_t        state;
  csc_state_t        state_next;
  logic [DIM_W-1:0]  h;
  logic [DIM_W-1:0]  w;
  logic [DIM_W-1:0]  h_m1;
  logic [DIM_W-1:0]  w_m1;
  logic [DIM_W-1:0]  r;
  logic [DIM_W-1:0]  c;
  logic              exh;
  logic              zero_done;

  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic [DIM_W-1:0]  o_row;
  logic [DIM_W-1:0]  o_col;
  logic              o_col_last;

  logic              run;
  logic              last_row;
  logic              last_col;
  logic              load_slot;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              consume;
  logic              flag_err;
  logic              set_exh;
  logic              final_load;
  logic              accept_en;

  logic              p_valid;
  logic [TOKEN_W-1:0] p_bits;
  csc_token_t        p_tok;

  assign h_m1     = h - DIM_W'(1);
  assign w_m1     = w - DIM_W'(1);
  assign run      = (state == RUN);
  assign last_row = (r == h_m1);
  assign last_col = (c == w_m1);
  assign p_tok    = csc_token_t'(p_bits);

  // No new tokens once the final element is being loaded; P is emptied outside RUN.
  assign accept_en = run && !final_load;

  csc_token_skid u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (!run),
    .accept_en (accept_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_token  ({in_data, in_row, in_last, in_empty}),
    .consume   (consume),
    .p_valid   (p_valid),
    .p_token   (p_bits)
  );

  // Decide what the output register takes this cycle and what happens to P.
  // A dropped (erroneous) token still yields a zero so the dense walk keeps its pace.
  always_comb begin
    load_slot = run && (!o_valid || out_ready);
    load      = 1'b0;
    load_data = '0;
    consume   = 1'b0;
    flag_err  = 1'b0;
    set_exh   = 1'b0;
    if (load_slot) begin
      if (exh) begin
        load = 1'b1;
      end else if (p_valid) begin
        load = 1'b1;
        if (p_tok.empty) begin
          consume = last_row;
        end else if (p_tok.row >= h || p_tok.row < r) begin
          consume  = 1'b1;
          flag_err = 1'b1;
          set_exh  = p_tok.last;
        end else if (p_tok.row == r) begin
          consume = 1'b1;
          if (last_row && !p_tok.last) begin
            flag_err = 1'b1;
          end else begin
            load_data = p_tok.data;
            set_exh   = p_tok.last;
          end
        end
      end
    end
    final_load = load && last_row && last_col;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && matrix_height != '0 && matrix_width != '0) state_next = RUN;
      RUN:     if (final_load) state_next = FLUSH;
      FLUSH:   if (o_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = zero_done || (state == FLUSH && o_valid && out_ready);
  end

  // Counters, dimension latch, sticky error and the output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      h          <= '0;
      w          <= '0;
      r          <= '0;
      c          <= '0;
      exh        <= 1'b0;
      err        <= 1'b0;
      zero_done  <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_row      <= '0;
      o_col      <= '0;
      o_col_last <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      if (state == IDLE && start) begin
        h         <= matrix_height;
        w         <= matrix_width;
        r         <= '0;
        c         <= '0;
        exh       <= 1'b0;
        err       <= 1'b0;
        zero_done <= (matrix_height == '0) || (matrix_width == '0);
      end
      if (flag_err) begin
        err <= 1'b1;
      end
      if (load) begin
        o_valid    <= 1'b1;
        o_data     <= load_data;
        o_row      <= r;
        o_col      <= c;
        o_col_last <= last_row;
        if (last_row) begin
          r   <= '0;
          c   <= c + DIM_W'(1);
          exh <= 1'b0;
        end else begin
          r <= r + DIM_W'(1);
          if (set_exh) begin
            exh <= 1'b1;
          end
        end
      end else if (out_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = o_valid;
  assign out_data     = o_data;
  assign out_row      = o_row;
  assign out_col      = o_col;
  assign out_col_last = o_col_last;
endmodule

// File: tb/tb_csc_matrix_decoder.sv
// Directed bench for csc_matrix_decoder: hand-computed dense streams, handshake timing,
// stall stability, protocol errors, zero-size start and mid-matrix reset.
module tb_csc_matrix_decoder;
  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] matrix_height;
  logic [4:0] matrix_width;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_row;
  logic       in_last;
  logic       in_empty;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] out_row;
  logic [4:0] out_col;
  logic       out_col_last;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [7:0] tok_data  [1024];
  logic [4:0] tok_row   [1024];
  logic       tok_last  [1024];
  logic       tok_empty [1024];
  logic [7:0] exp_data  [1024];

  csc_matrix_decoder #(.DATA_W(8), .DIM_W(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .matrix_height (matrix_height),
    .matrix_width  (matrix_width),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_row        (in_row),
    .in_last       (in_last),
    .in_empty      (in_empty),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_col_last  (out_col_last),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic set_token(input int idx, input logic [7:0] d, input logic [4:0] rw,
                           input logic lst, input logic emp);
    tok_data[idx]  = d;
    tok_row[idx]   = rw;
    tok_last[idx]  = lst;
    tok_empty[idx] = emp;
  endtask

  task automatic clear_expected(input int n);
    for (int k = 0; k < n; k++) exp_data[k] = 8'h00;
  endtask

  // Offers tokens, advancing only on an observed handshake; optionally keeps offering a
  // dummy token afterwards to confirm the decoder refuses it.
  task automatic feed_tokens(input string name, input int n_tok, input int extra, input int max_cyc);
    int   idx;
    logic hs;
    idx = 0;
    for (int k = 0; k < max_cyc && idx < n_tok; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = tok_data[idx];
      in_row   = tok_row[idx];
      in_last  = tok_last[idx];
      in_empty = tok_empty[idx];
      #4;
      hs = in_ready;
      @(posedge clock);
      if (hs === 1'b1) idx++;
    end
    #1;
    in_valid = 1'b0;
    check_output({name, "_tokens_accepted"}, 32'(idx), 32'(n_tok));
    for (int k = 0; k < extra; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      in_row   = 5'd0;
      in_last  = 1'b1;
      in_empty = 1'b0;
      #4;
      check_output($sformatf("%s_in_ready_closed[%0d]", name, k), 32'(in_ready), 32'd0);
      in_valid = 1'b0;
    end
  endtask

  task automatic collect_outputs(input string name, input int hgt, input int n_out,
                                 input int ready_mode, input bit expect_done, input int max_cyc);
    int          got;
    int          cyc;
    int          first;
    int          last_hs;
    int          done_seen;
    int          done_at;
    logic        held;
    logic        hs;
    logic [31:0] held_vec;
    logic [31:0] cur_vec;
    got = 0; cyc = 0; first = -1; last_hs = -1; done_seen = 0; done_at = -1;
    held = 1'b0; held_vec = '0;
    while (got < n_out && cyc < max_cyc) begin
      @(negedge clock);
      cyc++;
      out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 1);
      #4;
      cur_vec = 32'({out_col_last, out_col, out_row, out_data});
      hs = out_valid && out_ready;
      if (held) begin
        check_output($sformatf("%s_hold_valid[%0d]", name, got), 32'(out_valid), 32'd1);
        check_output($sformatf("%s_hold_fields[%0d]", name, got), cur_vec, held_vec);
      end
      if (out_valid === 1'b1 && first < 0) first = cyc;
      if (done === 1'b1) begin
        done_seen++;
        done_at = (hs === 1'b1) ? got + 1 : got;
      end
      if (hs === 1'b1) begin
        check_output($sformatf("%s_data[%0d]", name, got), 32'(out_data), 32'(exp_data[got]));
        check_output($sformatf("%s_row[%0d]", name, got), 32'(out_row), 32'(got % hgt));
        check_output($sformatf("%s_col[%0d]", name, got), 32'(out_col), 32'(got / hgt));
        check_output($sformatf("%s_col_last[%0d]", name, got), 32'(out_col_last),
                     32'((got % hgt) == hgt - 1));
        if (got == 0) check_output({name, "_busy_running"}, 32'(busy), 32'd1);
        got++;
        last_hs = cyc;
      end
      held = out_valid && !out_ready;
      held_vec = cur_vec;
    end
    check_output({name, "_out_count"}, 32'(got), 32'(n_out));
    check_output({name, "_first_valid_cycle"}, 32'(first), 32'd3);
    if (ready_mode == 0)
      check_output({name, "_no_bubble_span"}, 32'(last_hs - first), 32'(n_out - 1));
    if (expect_done) begin
      check_output({name, "_done_count"}, 32'(done_seen), 32'd1);
      check_output({name, "_done_at_handshake"}, 32'(done_at), 32'(n_out));
    end else begin
      check_output({name, "_done_count"}, 32'(done_seen), 32'd0);
    end
  endtask

  task automatic apply_stimulus(input string name, input int hgt, input int wid, input int n_tok,
                                input int n_out, input int ready_mode, input int extra,
                                input bit expect_done);
    $display("[TB] scenario %s H=%0d W=%0d", name, hgt, wid);
    @(negedge clock);
    start         = 1'b1;
    matrix_height = 5'(hgt);
    matrix_width  = 5'(wid);
    fork
      begin
        @(negedge clock);
        start = 1'b0;
      end
      feed_tokens(name, n_tok, extra, 3 * n_out + 50);
      collect_outputs(name, hgt, n_out, ready_mode, expect_done, 3 * n_out + 50);
    join
    if (expect_done) begin
      @(negedge clock);
      #4;
      check_output({name, "_busy_after"}, 32'(busy), 32'd0);
      check_output({name, "_valid_after"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; matrix_height = '0; matrix_width = '0;
    in_valid = 1'b0; in_data = '0; in_row = '0; in_last = 1'b0; in_empty = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #4;
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_out_row", 32'(out_row), 32'd0);
    check_output("rst_out_col", 32'(out_col), 32'd0);
    check_output("rst_col_last", 32'(out_col_last), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);

    // 4x2: column 0 has 5 at row 1; column 1 has 7 at row 0 and 9 at row 3.
    set_token(0, 8'd5, 5'd1, 1'b1, 1'b0);
    set_token(1, 8'd7, 5'd0, 1'b0, 1'b0);
    set_token(2, 8'd9, 5'd3, 1'b1, 1'b0);
    clear_expected(8);
    exp_data[1] = 8'd5; exp_data[4] = 8'd7; exp_data[7] = 8'd9;
    apply_stimulus("basic", 4, 2, 3, 8, 0, 0, 1'b1);
    check_output("basic_err", 32'(err), 32'd0);

    // 3x3 with empty columns around a single nonzero.
    set_token(0, 8'd0, 5'd0, 1'b1, 1'b1);
    set_token(1, 8'd2, 5'd2, 1'b1, 1'b0);
    set_token(2, 8'd0, 5'd0, 1'b1, 1'b1);
    clear_expected(9);
    exp_data[5] = 8'd2;
    apply_stimulus("empty_cols", 3, 3, 3, 9, 0, 4, 1'b1);
    check_output("empty_cols_err", 32'(err), 32'd0);

    // Same stream as basic with backpressure.
    set_token(0, 8'd5, 5'd1, 1'b1, 1'b0);
    set_token(1, 8'd7, 5'd0, 1'b0, 1'b0);
    set_token(2, 8'd9, 5'd3, 1'b1, 1'b0);
    clear_expected(8);
    exp_data[1] = 8'd5; exp_data[4] = 8'd7; exp_data[7] = 8'd9;
    apply_stimulus("stall", 4, 2, 3, 8, 1, 0, 1'b1);
    check_output("stall_err", 32'(err), 32'd0);

    // Row order violation: second token (row 1) arrives after row 2.
    set_token(0, 8'd3, 5'd2, 1'b0, 1'b0);
    set_token(1, 8'd4, 5'd1, 1'b1, 1'b0);
    clear_expected(4);
    exp_data[2] = 8'd3;
    apply_stimulus("order_err", 4, 1, 2, 4, 0, 0, 1'b1);
    check_output("order_err_flag", 32'(err), 32'd1);

    // Zero-size start: done next cycle, nothing emitted, error flag cleared.
    $display("[TB] scenario zero_dim H=0 W=5");
    @(negedge clock);
    start = 1'b1; matrix_height = 5'd0; matrix_width = 5'd5;
    @(negedge clock);
    start = 1'b0;
    #4;
    check_output("zero_done_pulse", 32'(done), 32'd1);
    check_output("zero_busy", 32'(busy), 32'd0);
    check_output("zero_err_cleared", 32'(err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #4;
      check_output($sformatf("zero_done_low[%0d]", k), 32'(done), 32'd0);
      check_output($sformatf("zero_no_valid[%0d]", k), 32'(out_valid), 32'd0);
    end

    // Mid-matrix reset after three handshakes.
    set_token(0, 8'd5, 5'd1, 1'b1, 1'b0);
    set_token(1, 8'd7, 5'd0, 1'b0, 1'b0);
    clear_expected(8);
    exp_data[1] = 8'd5;
    apply_stimulus("abort", 4, 2, 2, 3, 0, 0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_output("abort_in_ready", 32'(in_ready), 32'd0);
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_out_data", 32'(out_data), 32'd0);
    check_output("abort_out_row", 32'(out_row), 32'd0);
    check_output("abort_out_col", 32'(out_col), 32'd0);
    check_output("abort_col_last", 32'(out_col_last), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_err", 32'(err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      check_output($sformatf("abort_no_done[%0d]", k), 32'(done), 32'd0);
      check_output($sformatf("abort_idle_valid[%0d]", k), 32'(out_valid), 32'd0);
      @(negedge clock);
    end

    // Fully dense 31x31 at full rate.
    for (int i = 0; i < 961; i++) begin
      set_token(i, 8'((i % 255) + 1), 5'(i % 31), (i % 31) == 30, 1'b0);
      exp_data[i] = 8'((i % 255) + 1);
    end
    apply_stimulus("dense", 31, 31, 961, 961, 0, 0, 1'b1);
    check_output("dense_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
